datapath: RTL and testbench

Single-bus 32-bit Mini SRC datapath slice with a register subset (R1, R3, R5, PC, IR, MAR, MDR, Y, 64-bit Z) and a combinational ALU. An external control sequencer drives the per-register load and bus-drive strobes, and the ALU opcode, one cycle at a time. The block exposes every register and the bus for observation.

---
 rtl/datapath.sv | 146 ++++++++++++++
 tb/tb_datapath.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Mini SRC single-bus datapath slice: register subset, fixed-priority bus mux and
// combinational ALU feeding a 64-bit Z register.
module datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        R1_in,
    input  logic        R3_in,
    input  logic        R5_in,
    input  logic        PC_in,
    input  logic        IR_in,
    input  logic        Y_in,
    input  logic        MAR_in,
    input  logic        MDR_in,
    input  logic        Z_in,
    input  logic        Read,
    input  logic        R3_out,
    input  logic        R5_out,
    input  logic        PC_out,
    input  logic        Zlow_out,
    input  logic        MDR_out,
    input  logic [4:0]  alu_instruction,
    input  logic [31:0] Mdatain,
    output logic [31:0] Bus_Data,
    output logic [31:0] R1_Data,
    output logic [31:0] R3_Data,
    output logic [31:0] R5_Data,
    output logic [31:0] PC_Data,
    output logic [31:0] IR_Data,
    output logic [31:0] MAR_Data,
    output logic [31:0] MDR_Data,
    output logic [31:0] Y_Data,
    output logic [31:0] Zhigh_Data,
    output logic [31:0] Zlow_Data
);

    localparam logic [4:0] OpInc  = 5'b00000;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpShr  = 5'b00111;
    localparam logic [4:0] OpShra = 5'b01000;
    localparam logic [4:0] OpShl  = 5'b01001;
    localparam logic [4:0] OpRor  = 5'b01010;
    localparam logic [4:0] OpRol  = 5'b01011;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;

    logic [31:0] r1_q, r3_q, r5_q, pc_q, ir_q, mar_q, mdr_q, y_q, zhigh_q, zlow_q;
    logic [31:0] bus;
    logic [63:0] alu_result;

    always_comb begin
        if (MDR_out)       bus = mdr_q;
        else if (Zlow_out) bus = zlow_q;
        else if (PC_out)   bus = pc_q;
        else if (R5_out)   bus = r5_q;
        else if (R3_out)   bus = r3_q;
        else               bus = 32'h0;
    end

    logic [31:0]        alu_a, alu_b;
    logic [4:0]         shamt;
    logic signed [31:0] sa, sb;
    logic signed [63:0] product;

    assign alu_a   = y_q;
    assign alu_b   = bus;
    assign shamt   = bus[4:0];
    assign sa      = $signed(alu_a);
    assign sb      = $signed(alu_b);
    assign product = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});

    always_comb begin
        alu_result = 64'h0;
        unique case (alu_instruction)
            OpInc:  alu_result[31:0] = alu_b + 32'd1;
            OpAdd:  alu_result[31:0] = alu_a + alu_b;
            OpSub:  alu_result[31:0] = alu_a - alu_b;
            OpAnd:  alu_result[31:0] = alu_a & alu_b;
            OpOr:   alu_result[31:0] = alu_a | alu_b;
            OpShr:  alu_result[31:0] = alu_a >> shamt;
            OpShra: alu_result[31:0] = sa >>> shamt;
            OpShl:  alu_result[31:0] = alu_a << shamt;
            OpRor:  alu_result[31:0] = (alu_a >> shamt) | (alu_a << (6'd32 - {1'b0, shamt}));
            OpRol:  alu_result[31:0] = (alu_a << shamt) | (alu_a >> (6'd32 - {1'b0, shamt}));
            OpMul:  alu_result = product;
            OpDiv: begin
                // MIN / -1 overflows; the wrapped quotient is MIN with no remainder.
                if (alu_b == 32'h0) begin
                    alu_result = 64'h0;
                end else if (alu_a == 32'h8000_0000 && alu_b == 32'hFFFF_FFFF) begin
                    alu_result = {32'h0, 32'h8000_0000};
                end else begin
                    alu_result = {sa % sb, sa / sb};
                end
            end
            OpNeg:  alu_result[31:0] = 32'h0 - alu_b;
            OpNot:  alu_result[31:0] = ~alu_b;
            default: alu_result = 64'h0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r1_q    <= 32'h0;
            r3_q    <= 32'h0;
            r5_q    <= 32'h0;
            pc_q    <= 32'h0;
            ir_q    <= 32'h0;
            mar_q   <= 32'h0;
            mdr_q   <= 32'h0;
            y_q     <= 32'h0;
            zhigh_q <= 32'h0;
            zlow_q  <= 32'h0;
        end else begin
            if (R1_in)  r1_q  <= bus;
            if (R3_in)  r3_q  <= bus;
            if (R5_in)  r5_q  <= bus;
            if (PC_in)  pc_q  <= bus;
            if (IR_in)  ir_q  <= bus;
            if (Y_in)   y_q   <= bus;
            if (MAR_in) mar_q <= bus;
            if (MDR_in) mdr_q <= Read ? Mdatain : bus;
            if (Z_in) begin
                zhigh_q <= alu_result[63:32];
                zlow_q  <= alu_result[31:0];
            end
        end
    end

    assign Bus_Data   = bus;
    assign R1_Data    = r1_q;
    assign R3_Data    = r3_q;
    assign R5_Data    = r5_q;
    assign PC_Data    = pc_q;
    assign IR_Data    = ir_q;
    assign MAR_Data   = mar_q;
    assign MDR_Data   = mdr_q;
    assign Y_Data     = y_q;
    assign Zhigh_Data = zhigh_q;
    assign Zlow_Data  = zlow_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed Mini SRC sequences plus random strobes,
// compared against an arithmetic reference model.
module tb_datapath;

    logic        clk, clr;
    logic        R1_in, R3_in, R5_in, PC_in, IR_in, Y_in, MAR_in, MDR_in, Z_in, Read;
    logic        R3_out, R5_out, PC_out, Zlow_out, MDR_out;
    logic [4:0]  alu_instruction;
    logic [31:0] Mdatain;
    logic [31:0] Bus_Data, R1_Data, R3_Data, R5_Data, PC_Data, IR_Data, MAR_Data, MDR_Data;
    logic [31:0] Y_Data, Zhigh_Data, Zlow_Data;

    datapath dut (
        .clk(clk), .clr(clr),
        .R1_in(R1_in), .R3_in(R3_in), .R5_in(R5_in), .PC_in(PC_in), .IR_in(IR_in),
        .Y_in(Y_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .Z_in(Z_in), .Read(Read),
        .R3_out(R3_out), .R5_out(R5_out), .PC_out(PC_out), .Zlow_out(Zlow_out),
        .MDR_out(MDR_out), .alu_instruction(alu_instruction), .Mdatain(Mdatain),
        .Bus_Data(Bus_Data), .R1_Data(R1_Data), .R3_Data(R3_Data), .R5_Data(R5_Data),
        .PC_Data(PC_Data), .IR_Data(IR_Data), .MAR_Data(MAR_Data), .MDR_Data(MDR_Data),
        .Y_Data(Y_Data), .Zhigh_Data(Zhigh_Data), .Zlow_Data(Zlow_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference register file
    logic [31:0] m_r1, m_r3, m_r5, m_pc, m_ir, m_mar, m_mdr, m_y, m_zh, m_zl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        int unsigned n;
        logic [31:0] lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b % 32);
        lo = 32'h0;
        case (op)
            5'd0:  lo = b + 1;
            5'd3:  lo = a + b;
            5'd4:  lo = a - b;
            5'd5:  lo = a & b;
            5'd6:  lo = a | b;
            5'd7:  lo = a >> n;
            5'd8:  lo = 32'((sa - (sa % (longint'(1) << n) + (longint'(1) << n)) % (longint'(1) << n)) / (longint'(1) << n));
            5'd9:  lo = a << n;
            5'd10: lo = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
            5'd11: lo = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
            5'd15: return 64'(sa * sb);
            5'd16: begin
                if (sb == 0) return 64'h0;
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            5'd17: lo = 32'h0 - b;
            5'd18: lo = ~b;
            default: lo = 32'h0;
        endcase
        return {32'h0, lo};
    endfunction

    task automatic idle_ctrl();
        {R1_in, R3_in, R5_in, PC_in, IR_in, Y_in, MAR_in, MDR_in, Z_in, Read} = '0;
        {R3_out, R5_out, PC_out, Zlow_out, MDR_out} = '0;
        alu_instruction = 5'd0;
        Mdatain = 32'h0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".R1"}, {32'h0, R1_Data}, {32'h0, m_r1});
        check({tag, ".R3"}, {32'h0, R3_Data}, {32'h0, m_r3});
        check({tag, ".R5"}, {32'h0, R5_Data}, {32'h0, m_r5});
        check({tag, ".PC"}, {32'h0, PC_Data}, {32'h0, m_pc});
        check({tag, ".IR"}, {32'h0, IR_Data}, {32'h0, m_ir});
        check({tag, ".MAR"}, {32'h0, MAR_Data}, {32'h0, m_mar});
        check({tag, ".MDR"}, {32'h0, MDR_Data}, {32'h0, m_mdr});
        check({tag, ".Y"}, {32'h0, Y_Data}, {32'h0, m_y});
        check({tag, ".Z"}, {Zhigh_Data, Zlow_Data}, {m_zh, m_zl});
    endtask

    task automatic model_clear();
        {m_r1, m_r3, m_r5, m_pc, m_ir, m_mar, m_mdr, m_y, m_zh, m_zl} = '0;
    endtask

    // Called just after a falling edge with controls already driven.
    task automatic cycle(input string tag);
        logic [31:0] eb;
        logic [63:0] ez;
        #1;
        if (MDR_out)       eb = m_mdr;
        else if (Zlow_out) eb = m_zl;
        else if (PC_out)   eb = m_pc;
        else if (R5_out)   eb = m_r5;
        else if (R3_out)   eb = m_r3;
        else               eb = 32'h0;
        check({tag, ".bus"}, {32'h0, Bus_Data}, {32'h0, eb});
        ez = ref_alu(alu_instruction, m_y, eb);
        @(posedge clk);
        if (R1_in)  m_r1  = eb;
        if (R3_in)  m_r3  = eb;
        if (R5_in)  m_r5  = eb;
        if (PC_in)  m_pc  = eb;
        if (IR_in)  m_ir  = eb;
        if (Y_in)   m_y   = eb;
        if (MAR_in) m_mar = eb;
        if (MDR_in) m_mdr = Read ? Mdatain : eb;
        if (Z_in)   {m_zh, m_zl} = ez;
        #1;
        check_regs(tag);
        @(negedge clk);
        idle_ctrl();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1'b1; MDR_in = 1'b1;
        cycle("ldmdr");
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        MDR_out = 1'b1; Y_in = 1'b1;
        cycle("ldy");
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] b);
        load_mdr(b);
        MDR_out = 1'b1; Z_in = 1'b1; alu_instruction = op;
        cycle("alu");
    endtask

    // Asynchronous reset between edges, held across one enabled edge.
    task automatic reset_pulse(input string tag);
        #2;
        clr = 1'b0;
        #1;
        model_clear();
        check_regs({tag, ".async"});
        R1_in = 1'b1; PC_in = 1'b1; Z_in = 1'b1; MDR_in = 1'b1; Read = 1'b1;
        Mdatain = 32'h1234_5678;
        @(posedge clk);
        #1;
        check_regs({tag, ".hold"});
        check({tag, ".bus0"}, {32'h0, Bus_Data}, 64'h0);
        @(negedge clk);
        clr = 1'b1;
        idle_ctrl();
    endtask

    initial begin
        idle_ctrl();
        model_clear();
        clr = 1'b0;
        #1;
        check_regs("por");
        check("por.bus", {32'h0, Bus_Data}, 64'h0);
        @(negedge clk);
        clr = 1'b1;

        // Preload R3, R5, R1 via MDR
        load_mdr(32'h8000_FA92);
        check("pre.mdr", {32'h0, MDR_Data}, {32'h0, 32'h8000_FA92});
        MDR_out = 1'b1; R3_in = 1'b1; cycle("pre.r3");
        check("pre.r3v", {32'h0, R3_Data}, {32'h0, 32'h8000_FA92});
        load_mdr(32'hA);
        MDR_out = 1'b1; R5_in = 1'b1; cycle("pre.r5");
        load_mdr(32'h595);
        MDR_out = 1'b1; R1_in = 1'b1; cycle("pre.r1");
        check("pre.r1v", {32'h0, R1_Data}, {32'h0, 32'h595});

        // Reset clears everything, then preload again
        reset_pulse("rst1");
        load_mdr(32'h8000_FA92);
        MDR_out = 1'b1; R3_in = 1'b1; cycle("re.r3");
        load_mdr(32'hA);
        MDR_out = 1'b1; R5_in = 1'b1; cycle("re.r5");
        load_mdr(32'h595);
        MDR_out = 1'b1; R1_in = 1'b1; cycle("re.r1");

        // shr R1, R3, R5 instruction from PC=0
        PC_out = 1'b1; MAR_in = 1'b1; Z_in = 1'b1; alu_instruction = 5'd0; cycle("t0");
        Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1;
        Mdatain = 32'h389A_8000; cycle("t1");
        MDR_out = 1'b1; IR_in = 1'b1; cycle("t2");
        R3_out = 1'b1; Y_in = 1'b1; cycle("t3");
        R5_out = 1'b1; Z_in = 1'b1; alu_instruction = IR_Data[31:27]; cycle("t4");
        Zlow_out = 1'b1; R1_in = 1'b1; cycle("t5");
        check("shr.pc", {32'h0, PC_Data}, 64'h1);
        check("shr.mar", {32'h0, MAR_Data}, 64'h0);
        check("shr.ir", {32'h0, IR_Data}, {32'h0, 32'h389A_8000});
        check("shr.r1", {Zhigh_Data, R1_Data}, {32'h0, 32'h0020_003E});

        // Shifts and rotates with Y=0x8000FA92, B=R5=0xA
        R5_out = 1'b1; Z_in = 1'b1; alu_instruction = 5'd8; cycle("shra");
        check("shra.v", {Zhigh_Data, Zlow_Data}, {32'h0, 32'hFFE0_003E});
        R5_out = 1'b1; Z_in = 1'b1; alu_instruction = 5'd9; cycle("shl");
        check("shl.v", {Zhigh_Data, Zlow_Data}, {32'h0, 32'h03EA_4800});
        R5_out = 1'b1; Z_in = 1'b1; alu_instruction = 5'd10; cycle("ror");
        check("ror.v", {Zhigh_Data, Zlow_Data}, {32'h0, 32'hA4A0_003E});
        R5_out = 1'b1; Z_in = 1'b1; alu_instruction = 5'd11; cycle("rol");
        check("rol.v", {Zhigh_Data, Zlow_Data}, {32'h0, 32'h03EA_4A00});

        // mul / div
        load_y(32'hFFFF_FFFE);
        alu_op(5'd15, 32'd3);
        check("mul.v", {Zhigh_Data, Zlow_Data}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        load_y(32'd7);
        alu_op(5'd16, 32'hFFFF_FFFE);
        check("div.v", {Zhigh_Data, Zlow_Data}, {32'h1, 32'hFFFF_FFFD});
        alu_op(5'd16, 32'h0);
        check("div0.v", {Zhigh_Data, Zlow_Data}, 64'h0);

        // Bus priority and add wrap
        load_mdr(32'hCAFE_0001);
        MDR_out = 1'b1; R3_out = 1'b1; R5_in = 1'b1; cycle("prio");
        check("prio.r5", {32'h0, R5_Data}, {32'h0, 32'hCAFE_0001});
        load_y(32'hFFFF_FFFF);
        alu_op(5'd3, 32'd1);
        check("addwrap", {Zhigh_Data, Zlow_Data}, 64'h0);

        // Random strobes; the reference model checks every cycle
        for (int i = 0; i < 400; i++) begin
            {R1_in, R3_in, R5_in, PC_in, IR_in, Y_in, MAR_in, MDR_in, Z_in, Read} =
                10'($urandom);
            {R3_out, R5_out, PC_out, Zlow_out, MDR_out} = 5'($urandom);
            alu_instruction = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                              : 5'($urandom_range(0, 18));
            Mdatain = $urandom;
            if ($urandom_range(0, 40) == 0) begin
                reset_pulse("rnd.rst");
            end else begin
                cycle("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
